// File: rtl/wb_pkg.sv
// Shared Wishbone encodings and FSM state type for the RAM responder.
// Cycle-type and burst-type codes follow the Wishbone B4 registered-feedback tags.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_BURST = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Only linear incrementing bursts are supported; any other wrap mode is refused.
  function automatic logic bad_burst(input logic [2:0] cti, input logic [1:0] bte);
    return (cti == CTI_INCR) && (bte != BTE_LINEAR);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port RAM: synchronous read with one cycle of latency, byte-enable write.
// A read on the same cycle as a write to that address returns the old word.
module sram_1rw #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset on purpose; contents must survive a bus reset,
  // and a reset port would prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone B4 slave fronting a single-port RAM, with classic cycles and
// linear incrementing bursts. Beats in a burst are zero-wait after the first.
module wb_ram_responder
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_next;
  logic [ADDR_WIDTH-1:0] adr_idx;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            cnt_q;
  logic [2:0]            cti_q;
  logic                  we_q;
  logic                  valid;
  logic                  beat;
  logic                  mem_we;
  logic [31:0]           rdata;
  logic                  unused_adr;

  assign valid    = cyc_i & stb_i;
  assign adr_idx  = adr_i[ADDR_WIDTH+1:2];
  assign idx_next = idx_q + ADDR_WIDTH'(1);
  assign unused_adr = ^{adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};

  // A beat completes in the same cycle the master strobes, so a stalled burst
  // (stb low) simply produces no ack and leaves the word counter alone.
  assign beat   = valid & (((state_q == ST_WAIT) & (cnt_q == '0)) | (state_q == ST_BURST));
  assign mem_we = beat & we_q;

  assign ack_o = beat;
  assign dat_o = (beat & ~we_q) ? rdata : '0;
  // The refusal is signalled in the accept cycle itself; gating with reset keeps
  // it quiet while the bus may still be driving a request during reset.
  assign err_o = reset_n_i & (state_q == ST_IDLE) & valid & bad_burst(cti_i, bte_i);

  // Reads look one word ahead on every acked beat so the next beat's data is
  // already out of the RAM; writes always target the address on the bus.
  always_comb begin
    // NOTE: default first so every path assigns mem_addr and no latch is inferred.
    mem_addr = idx_q;
    case (state_q)
      ST_IDLE:  mem_addr = adr_idx;
      ST_WAIT:  if (!we_q && beat) mem_addr = idx_next;
      ST_BURST: begin
        if (we_q)      mem_addr = adr_idx;
        else if (beat) mem_addr = idx_next;
      end
      default:  ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cti_q   <= CTI_CLASSIC;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            if (bad_burst(cti_i, bte_i)) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= adr_idx;
              cti_q   <= cti_i;
              we_q    <= we_i;
              cnt_q   <= WAIT_LOAD;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!cyc_i) begin
            state_q <= ST_DONE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (beat) begin
            idx_q   <= idx_next;
            state_q <= (cti_q == CTI_INCR && cti_i == CTI_INCR) ? ST_BURST : ST_DONE;
          end
        end
        ST_BURST: begin
          if (!cyc_i) begin
            state_q <= ST_DONE;
          end else if (beat) begin
            idx_q <= idx_next;
            if (cti_i != CTI_INCR) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sram_1rw #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_sram (
    .clk   (clock_i),
    .we    (mem_we),
    .be    (sel_i),
    .addr  (mem_addr),
    .wdata (dat_i),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: classic and burst cycles, byte lanes,
// stalls, refused bursts, address wrap and reset in mid-transaction.
module tb_wb_ram_responder;
  import wb_pkg::*;

  localparam int AW = 12;
  localparam int WS = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  wb_ram_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .adr_i     (adr),
    .dat_i     (dat_w),
    .sel_i     (sel),
    .we_i      (we),
    .cyc_i     (cyc),
    .stb_i     (stb),
    .cti_i     (cti),
    .bte_i     (bte),
    .dat_o     (dat_r),
    .ack_o     (ack),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Called from the accept cycle; walks the wait states and lands on the first ack.
  task automatic await_ack(input string tag);
    for (int i = 1; i < WS; i++) begin
      step();
      sample();
      check({tag, "_wait"}, 32'(ack), 32'd0);
    end
    step();
    sample();
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_noerr"}, 32'(err), 32'd0);
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    sample();
    check({tag, "_idle"}, 32'(ack), 32'd0);
    await_ack(tag);
    rd = dat_r;
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sample();
    check({tag, "_done"}, 32'(ack), 32'd0);
    step();
  endtask

  // Reads compare against v*, writes drive v* as data; stall_at=k inserts
  // stall_len strobe-low cycles after beat k.
  task automatic burst(input logic w, input logic [31:0] a, input int n,
                       input int stall_at, input int stall_len,
                       input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3, input string tag);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = v[0]; sel = 4'hF;
    cti = (n == 1) ? CTI_END : CTI_INCR; bte = BTE_LINEAR;
    sample();
    check({tag, "_idle"}, 32'(ack), 32'd0);
    for (int b = 0; b < n; b++) begin
      if (b == 0) begin
        await_ack(tag);
      end else begin
        step();
        stb = 1'b1; adr = a + 32'(4 * b); dat_w = v[b];
        cti = (b == n - 1) ? CTI_END : CTI_INCR;
        sample();
        check({tag, "_beat"}, 32'(ack), 32'd1);
      end
      if (!w) check({tag, "_dat"}, dat_r, v[b]);
      if (b + 1 == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          step();
          stb = 1'b0;
          sample();
          check({tag, "_stall"}, 32'(ack), 32'd0);
        end
      end
    end
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sample();
    check({tag, "_end"}, 32'(ack), 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;

    // Outputs stay quiet in reset even with a refusable request on the bus.
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; cti = CTI_INCR; bte = 2'b01;
    sample();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dat", dat_r, 32'd0);
    step();
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    rst_n = 1'b1;

    // Write then read with the strobe held through DONE: the read is accepted
    // only once the FSM is back in IDLE.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; dat_w = 32'hDEAD_BEEF; sel = 4'hF;
    sample();
    check("b2b_wr_idle", 32'(ack), 32'd0);
    await_ack("b2b_wr");
    step();
    we = 1'b0; dat_w = '0;
    sample();
    check("b2b_done", 32'(ack), 32'd0);
    step();
    sample();
    check("b2b_rd_idle", 32'(ack), 32'd0);
    await_ack("b2b_rd");
    check("b2b_rd_data", dat_r, 32'hDEAD_BEEF);
    step();
    cyc = 1'b0; stb = 1'b0;
    sample();
    check("b2b_rd_done", 32'(ack), 32'd0);
    step();

    // Single-lane write, then a read with no lanes selected still returns the word.
    classic(1'b1, 32'h40, 32'h0000_00AA, 4'b0001, "lane_wr", rd);
    classic(1'b0, 32'h40, 32'h0, 4'b0000, "lane_rd", rd);
    check("lane_data", rd, 32'hDEAD_BEAA);

    burst(1'b1, 32'h100, 4, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4, "bw");
    burst(1'b0, 32'h100, 4, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4, "br");
    burst(1'b0, 32'h100, 4, 2, 2, 32'd1, 32'd2, 32'd3, 32'd4, "bstall");

    // Wrapped-burst request is refused in its accept cycle and writes nothing.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; dat_w = 32'h5555_5555; sel = 4'hF;
    cti = CTI_INCR; bte = 2'b01;
    sample();
    check("bte_err", 32'(err), 32'd1);
    check("bte_ack", 32'(ack), 32'd0);
    step();
    sample();
    check("bte_err_once", 32'(err), 32'd0);
    check("bte_done_ack", 32'(ack), 32'd0);
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    classic(1'b0, 32'h40, 32'h0, 4'hF, "bte_rd", rd);
    check("bte_mem", rd, 32'hDEAD_BEAA);

    // Last word of the 4K-word space wraps to word 0.
    classic(1'b1, 32'h3FFC, 32'hCAFE_F00D, 4'hF, "wrap_p0", rd);
    classic(1'b1, 32'h0000, 32'h0BAD_C0DE, 4'hF, "wrap_p1", rd);
    burst(1'b0, 32'h3FFC, 2, 0, 0, 32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h0, 32'h0, "wrap");

    // Reset asserted during the ack cycle of a write: ack drops at once, no write lands.
    classic(1'b1, 32'h80, 32'h1111_1111, 4'hF, "rstw_pre", rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; dat_w = 32'h2222_2222; sel = 4'hF;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    sample();
    check("rstw_idle", 32'(ack), 32'd0);
    for (int i = 1; i < WS; i++) begin
      step();
      sample();
      check("rstw_wait", 32'(ack), 32'd0);
    end
    step();
    #1;
    check("rstw_pre_ack", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_ack", 32'(ack), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_dat", dat_r, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    classic(1'b0, 32'h80, 32'h0, 4'hF, "rstw_rd", rd);
    check("rstw_mem", rd, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
